shift_frame_receiver: RTL and testbench
=======================================

SHIFT_FRAME_RECEIVER -- requirements
Module: shift_frame_receiver

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data bits per frame (legal range 2..16).
REQ-002 SHALL have parameter PARITY_EN, default 1; 1 means an even-parity bit follows the data bits, 0 means no parity bit.
REQ-003 SHALL have port CLK  input  1  single clock; all state SHALL update on the falling edge.
REQ-004 SHALL have port RES  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port si  input  1  serial line; idles at 1.
REQ-006 SHALL have port en  input  1  bit strobe; si is sampled only on edges where en=1.
REQ-007 SHALL have port dir  input  1  bit order; 0 = LSB first, 1 = MSB first; sampled at the start bit and held for the frame.
REQ-008 SHALL have port rd_ack  input  1  consumer acknowledge of dout.
REQ-009 SHALL have port dout  output  WIDTH  last received word.
REQ-010 SHALL have port valid  output  1  dout holds an unacknowledged word.
REQ-011 SHALL have port par_err  output  1  parity mismatch for the word in dout.
REQ-012 SHALL have port frm_err  output  1  one-cycle pulse on a bad stop bit.
REQ-013 SHALL have port overrun  output  1  sticky; an unacknowledged word was overwritten.
REQ-014 SHALL have port busy  output  1  FSM not in IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, DATA, PARITY, STOP; no FSM transitions SHALL occur on edges with en=0.
REQ-016 IDLE: si=0 with en=1 SHALL be taken as the start bit -> DATA. The edge SHALL latch dir, clear the bit counter and clear the shift register.
REQ-017 DATA: each strobed edge SHALL shift si into the register.
  - dir=0: si enters at bit WIDTH-1 and the register shifts right.
  - dir=1: si enters at bit 0 and the register shifts left.
REQ-018 DATA: after the WIDTH-th data bit, the FSM SHALL go to PARITY if PARITY_EN=1, else to STOP.
REQ-019 PARITY: the FSM SHALL capture si as the received parity bit -> STOP.
REQ-020 STOP with si=1: on that edge the FSM SHALL load dout, set valid=1, and set par_err = (XOR of data bits XOR parity bit), or 0 if PARITY_EN=0, then go to IDLE.
REQ-021 STOP with si=0: the FSM SHALL pulse frm_err=1 for exactly one cycle, discard the word, leave dout/valid/par_err unchanged, and go to IDLE.
REQ-022 Latency: valid SHALL rise on the same edge that samples a good stop bit.
REQ-023 rd_ack=1 while valid=1 SHALL clear valid and overrun on the next edge; rd_ack with valid=0 SHALL be ignored.
REQ-024 If a good stop bit arrives while valid=1 and rd_ack=0, the new word SHALL overwrite dout/par_err, valid SHALL stay 1 and overrun SHALL be set.
REQ-025 If a good stop bit and rd_ack=1 occur on the same edge, the new word SHALL load, valid SHALL stay 1 and overrun SHALL be cleared.
REQ-026 dir and PARITY_EN changes mid-frame SHALL have no effect on the frame in progress.
REQ-027 The block SHALL accept back-to-back frames: a start bit may immediately follow a stop bit.

Reset
REQ-028 RES=0 SHALL immediately force: FSM=IDLE, counter=0, shift register=0, dout=0, valid=0, par_err=0, frm_err=0, overrun=0, busy=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no partial word delivered; after RES=1, the next start bit SHALL begin a fresh frame.

Verification (WIDTH=4, PARITY_EN=1, en=1 every cycle unless stated)
REQ-030 LSB-first good frame: dir=0, si = 0,1,1,0,1,1,1 (start, data 1,1,0,1, parity 1, stop 1) -> dout=4'b1011, valid=1, par_err=0, on the stop edge.
REQ-031 MSB-first with parity error: dir=1, si = 0,1,0,1,1,0,1 -> dout=4'b1011, valid=1, par_err=1.
REQ-032 Framing error: the REQ-030 sequence with stop bit 0 -> frm_err high for 1 cycle; valid, dout and overrun unchanged; busy=0 next cycle.
REQ-033 Overrun: two REQ-030 frames back-to-back with rd_ack=0 -> overrun=1 after the second; rd_ack=1 for one cycle -> valid=0, overrun=0.
REQ-034 Strobed sampling and reset: en=1 every 3rd cycle, REQ-030 sequence -> same result as REQ-030; RES pulsed low after 2 data bits -> all outputs 0, and the next full frame decodes correctly.

Source files
------------

// File: rtl/shift_frame_receiver.sv
// Serial frame receiver: start bit, WIDTH data bits (LSB- or MSB-first), optional
// even parity, stop bit. All state advances on the falling edge of CLK.
module shift_frame_receiver #(
  parameter int WIDTH     = 4,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             si,
  input  logic             en,
  input  logic             dir,
  input  logic             rd_ack,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             par_err,
  output logic             frm_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sh;
  logic             dir_q;
  logic             par_bit;
  logic             start_bit, shift_bit, good_stop, bad_stop;

  function automatic logic parity_err(input logic [WIDTH-1:0] d, input logic p);
    return PARITY_EN ? ((^d) ^ p) : 1'b0;
  endfunction

  // dir=0 fills from the top and shifts right; dir=1 fills from bit 0 and shifts left
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] d,
                                                input logic b, input logic msb_first);
    return msb_first ? {d[WIDTH-2:0], b} : {b, d[WIDTH-1:1]};
  endfunction

  always_ff @(negedge CLK or negedge RES) begin
    if (!RES) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    start_bit = 1'b0;
    shift_bit = 1'b0;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    if (en) begin
      case (state)
        IDLE: begin
          if (!si) begin
            start_bit = 1'b1;
            state_nx  = DATA;
          end
        end
        DATA: begin
          shift_bit = 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state_nx = PARITY_EN ? PARITY : STOP;
        end
        PARITY: state_nx = STOP;
        STOP: begin
          good_stop = si;
          bad_stop  = !si;
          state_nx  = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Frame assembly: bit order is frozen at the start bit
  always_ff @(negedge CLK or negedge RES) begin
    if (!RES) begin
      cnt     <= '0;
      sh      <= '0;
      dir_q   <= 1'b0;
      par_bit <= 1'b0;
    end else begin
      if (start_bit) begin
        cnt   <= '0;
        sh    <= '0;
        dir_q <= dir;
      end else if (shift_bit) begin
        cnt <= cnt + 1'b1;
        sh  <= shift_in(sh, si, dir_q);
      end
      if (en && state == PARITY) par_bit <= si;
    end
  end

  // Delivery: a new word always wins over an acknowledge on the same edge
  always_ff @(negedge CLK or negedge RES) begin
    if (!RES) begin
      dout    <= '0;
      valid   <= 1'b0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      frm_err <= bad_stop;
      if (good_stop) begin
        dout    <= sh;
        valid   <= 1'b1;
        par_err <= parity_err(sh, par_bit);
        overrun <= valid & ~rd_ack;
      end else if (rd_ack && valid) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_shift_frame_receiver.sv
// Directed bench for shift_frame_receiver (WIDTH=4, PARITY_EN=1): inputs change
// on the rising edge, outputs are sampled 1ns after the falling (active) edge.
module tb_shift_frame_receiver;

  logic       CLK = 1'b0;
  logic       RES;
  logic       si, en, dir, rd_ack;
  logic [3:0] dout;
  logic       valid, par_err, frm_err, overrun, busy;

  int passed = 0;
  int total  = 0;

  localparam logic [6:0] SEQ_LSB_GOOD = 7'b0110111;
  localparam logic [6:0] SEQ_MSB_PERR = 7'b0101101;
  localparam logic [6:0] SEQ_BAD_STOP = 7'b0110110;

  shift_frame_receiver #(.WIDTH(4), .PARITY_EN(1'b1)) dut (
    .CLK(CLK), .RES(RES), .si(si), .en(en), .dir(dir), .rd_ack(rd_ack),
    .dout(dout), .valid(valid), .par_err(par_err), .frm_err(frm_err),
    .overrun(overrun), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_outs(input string tag, input logic [3:0] d, input logic v,
                            input logic p, input logic f, input logic o, input logic b);
    check({tag, ".dout"},    32'(dout),    32'(d));
    check({tag, ".valid"},   32'(valid),   32'(v));
    check({tag, ".par_err"}, 32'(par_err), 32'(p));
    check({tag, ".frm_err"}, 32'(frm_err), 32'(f));
    check({tag, ".overrun"}, 32'(overrun), 32'(o));
    check({tag, ".busy"},    32'(busy),    32'(b));
  endtask

  task automatic send_bit(input logic b, input logic ack);
    @(posedge CLK);
    si     = b;
    en     = 1'b1;
    rd_ack = ack;
    @(negedge CLK);
    #1;
    rd_ack = 1'b0;
  endtask

  task automatic send_frame(input logic [6:0] seq, input logic d, input logic flip,
                            input logic ack_stop);
    dir = d;
    for (int i = 6; i >= 0; i--) begin
      send_bit(seq[i], (i == 0) && ack_stop);
      if (i == 6 && flip) dir = ~dir;
    end
  endtask

  // Two unstrobed cycles carrying the wrong level, then the real strobed bit
  task automatic strobe_bit(input logic b);
    repeat (2) begin
      @(posedge CLK);
      si = ~b;
      en = 1'b0;
    end
    send_bit(b, 1'b0);
  endtask

  initial begin
    RES = 1'b0; si = 1'b1; en = 1'b0; dir = 1'b0; rd_ack = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check_outs("reset", 4'h0, 0, 0, 0, 0, 0);
    @(posedge CLK);
    RES = 1'b1;

    send_frame(SEQ_LSB_GOOD, 1'b0, 1'b0, 1'b0);
    check_outs("lsb_good", 4'b1011, 1, 0, 0, 0, 0);

    send_frame(SEQ_BAD_STOP, 1'b0, 1'b0, 1'b0);
    check_outs("frame_err", 4'b1011, 1, 0, 1, 0, 0);
    send_bit(1'b1, 1'b0);
    check_outs("frm_pulse_end", 4'b1011, 1, 0, 0, 0, 0);
    send_bit(1'b1, 1'b1);
    check_outs("ack1", 4'b1011, 0, 0, 0, 0, 0);

    // dir is flipped right after the start bit and must not affect this frame
    send_frame(SEQ_MSB_PERR, 1'b1, 1'b1, 1'b0);
    check_outs("msb_par_err", 4'b1011, 1, 1, 0, 0, 0);
    send_bit(1'b1, 1'b1);
    check_outs("ack2", 4'b1011, 0, 1, 0, 0, 0);
    send_bit(1'b1, 1'b1);
    check_outs("ack_no_valid", 4'b1011, 0, 1, 0, 0, 0);

    send_frame(SEQ_LSB_GOOD, 1'b0, 1'b0, 1'b0);
    check_outs("ovr_first", 4'b1011, 1, 0, 0, 0, 0);
    send_frame(SEQ_LSB_GOOD, 1'b0, 1'b0, 1'b0);
    check_outs("ovr_second", 4'b1011, 1, 0, 0, 1, 0);
    send_bit(1'b1, 1'b1);
    check_outs("ovr_ack", 4'b1011, 0, 0, 0, 0, 0);

    send_frame(SEQ_LSB_GOOD, 1'b0, 1'b0, 1'b0);
    send_frame(SEQ_LSB_GOOD, 1'b0, 1'b0, 1'b0);
    check_outs("ovr_again", 4'b1011, 1, 0, 0, 1, 0);
    send_frame(SEQ_MSB_PERR, 1'b1, 1'b0, 1'b1);
    check_outs("ack_same_edge", 4'b1011, 1, 1, 0, 0, 0);
    send_bit(1'b1, 1'b1);
    check_outs("ack3", 4'b1011, 0, 1, 0, 0, 0);

    dir = 1'b0;
    for (int i = 6; i >= 0; i--) strobe_bit(SEQ_LSB_GOOD[i]);
    check_outs("strobed", 4'b1011, 1, 0, 0, 0, 0);
    send_bit(1'b1, 1'b1);
    check_outs("ack4", 4'b1011, 0, 0, 0, 0, 0);

    dir = 1'b0;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check_outs("mid_frame", 4'b1011, 0, 0, 0, 0, 1);
    @(posedge CLK);
    RES = 1'b0;
    #1;
    check_outs("async_reset", 4'h0, 0, 0, 0, 0, 0);
    @(posedge CLK);
    RES = 1'b1;
    si  = 1'b1;
    en  = 1'b1;
    @(negedge CLK);
    #1;
    check_outs("post_reset_idle", 4'h0, 0, 0, 0, 0, 0);
    send_frame(SEQ_MSB_PERR, 1'b1, 1'b0, 1'b0);
    check_outs("post_reset_frame", 4'b1011, 1, 1, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
